div_ctrl_unit: RTL and testbench

- Control unit (FSM) for the iterative restoring divider.
- Drives the 3-bit loadable up/down iteration counter (ce/ld/ud/D) and consumes its zero flag.
- Sequences the dividend/remainder datapath (load, shift, subtract, quotient-bit set) and exposes a go/done/err handshake to the system.
- Sits between the top-level divider wrapper and the counter and datapath blocks.

---
 rtl/div_ctrl_unit.sv | 99 +++++++++
 tb/tb_div_ctrl_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl_unit.sv
// Control FSM for the iterative restoring divider: drives the iteration counter and the
// remainder/quotient datapath, and exposes a go/done/err handshake.
module div_ctrl_unit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             y_zero,
  input  logic             r_lt_y,
  input  logic             cnt_zero,
  output logic             cnt_ce,
  output logic             cnt_ld,
  output logic             cnt_ud,
  output logic [CNT_W-1:0] cnt_d,
  output logic             ld_xy,
  output logic             shl,
  output logic             r_ld,
  output logic             q_set,
  output logic             done,
  output logic             err,
  output logic [2:0]       cs
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCheck = 3'd2,
    StShift = 3'd3,
    StCmp   = 3'd4,
    StSub   = 3'd5,
    StTest  = 3'd6,
    StDone  = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic       err_d;
  logic [6:0] strb_q;

  // Strobe pattern {cnt_ce, cnt_ld, ld_xy, shl, r_ld, q_set, done} for a given state.
  function automatic logic [6:0] decode(state_e s);
    logic [6:0] v;
    v = 7'b0;
    case (s)
      StLoad:  v = 7'b1110000;
      StShift: v = 7'b1001000;
      StSub:   v = 7'b0000110;
      StDone:  v = 7'b0000001;
      default: v = 7'b0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    err_d   = err;
    unique case (state_q)
      StIdle:  if (go) state_d = StLoad;
      StLoad: begin
        err_d   = 1'b0;
        state_d = StCheck;
      end
      StCheck: begin
        if (y_zero) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StShift;
        end
      end
      StShift: state_d = StCmp;
      StCmp:   state_d = r_lt_y ? StTest : StSub;
      StSub:   state_d = StTest;
      StTest:  state_d = cnt_zero ? StDone : StShift;
      StDone:  if (!go) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they stay pure Moore and glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      err     <= 1'b0;
      strb_q  <= 7'b0;
    end else begin
      state_q <= state_d;
      err     <= err_d;
      strb_q  <= decode(state_d);
    end
  end

  assign {cnt_ce, cnt_ld, ld_xy, shl, r_ld, q_set, done} = strb_q;
  assign cnt_ud = 1'b0;
  assign cnt_d  = CNT_W'(WIDTH);
  assign cs     = state_q;

endmodule

// File: tb/tb_div_ctrl_unit.sv
// Bench for div_ctrl_unit: behavioural counter/datapath model, scoreboard of expected
// division results checked by a monitor when done is presented.
module tb_div_ctrl_unit;

  logic       clk, rst, go;
  logic       y_zero, r_lt_y, cnt_zero;
  logic       cnt_ce, cnt_ld, cnt_ud, ld_xy, shl, r_ld, q_set, done, err;
  logic [2:0] cnt_d, cs;

  logic [3:0] dx, dy;
  logic [3:0] x, y;
  logic [4:0] r;
  logic [2:0] cq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int q;
    int r;
    int e;
    int lat;
    int nq;
  } exp_t;
  exp_t sb[$];

  div_ctrl_unit #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .go(go), .y_zero(y_zero), .r_lt_y(r_lt_y), .cnt_zero(cnt_zero),
    .cnt_ce(cnt_ce), .cnt_ld(cnt_ld), .cnt_ud(cnt_ud), .cnt_d(cnt_d), .ld_xy(ld_xy),
    .shl(shl), .r_ld(r_ld), .q_set(q_set), .done(done), .err(err), .cs(cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter and datapath model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cq <= '0; x <= '0; y <= '0; r <= '0;
    end else begin
      if (cnt_ce) cq <= cnt_ld ? cnt_d : (cnt_ud ? cq + 3'd1 : cq - 3'd1);
      if (ld_xy) begin
        x <= dx; y <= dy; r <= '0;
      end else if (shl) begin
        {r, x} <= {r[3:0], x, 1'b0};
      end
      if (r_ld) r <= r - {1'b0, y};
      if (q_set) x[0] <= 1'b1;
    end
  end

  assign y_zero   = (y == 4'd0);
  assign r_lt_y   = (r < {1'b0, y});
  assign cnt_zero = (cq == 3'd0);

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: tracks one division from LOAD and checks it against the scoreboard at done.
  bit   active = 0;
  int   cyc, n_ld, n_dec, n_shl, n_rld, n_qs, n_up, n_badce, ldval;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else if (cs == 3'd1) begin
      active = 1; cyc = 0; n_dec = 0; n_shl = 0; n_rld = 0; n_qs = 0; n_badce = 0;
      n_ld = int'(cnt_ld); n_up = int'(cnt_ud); ldval = int'(cnt_d);
    end else if (active) begin
      cyc++;
      n_ld  += int'(cnt_ld);
      n_up  += int'(cnt_ud);
      n_shl += int'(shl);
      n_rld += int'(r_ld);
      n_qs  += int'(q_set);
      if (cnt_ce && !cnt_ld && !cnt_ud) n_dec++;
      if (cnt_ce && cs != 3'd3) n_badce++;
      if (done) begin
        active = 0;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("quotient", int'(x), e.q);
          check("remainder", int'(r), e.r);
          check("err", int'(err), e.e);
          check("latency", cyc, e.lat);
          check("cnt_ld_pulses", n_ld, 1);
          check("cnt_d", ldval, 4);
          check("dec_pulses", n_dec, e.e ? 0 : 4);
          check("shl_pulses", n_shl, e.e ? 0 : 4);
          check("r_ld_pulses", n_rld, e.nq);
          check("q_set_pulses", n_qs, e.nq);
          check("up_pulses", n_up, 0);
          check("stray_cnt_ce", n_badce, 0);
        end
      end
    end
  end

  task automatic start_div(input int a, input int b, input int q, input int rm, input int er,
                           input int lat, input int nq);
    exp_t t;
    t.q = q; t.r = rm; t.e = er; t.lat = lat; t.nq = nq;
    sb.push_back(t);
    dx = 4'(a); dy = 4'(b);
    go = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input bit toggle);
    int i;
    for (i = 0; i < 40 && !done; i++) begin
      if (toggle) go = ~go;
      @(negedge clk);
    end
    check("done_reached", int'(done), 1);
  endtask

  task automatic drop_go();
    go = 1'b0;
    @(negedge clk);
    check("idle_after_drop", int'(cs), 0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; dx = '0; dy = '0;
    @(negedge clk);
    check("reset_cs", int'(cs), 0);
    check("reset_err", int'(err), 0);
    check("reset_strobes", int'({cnt_ce, cnt_ld, cnt_ud, ld_xy, shl, r_ld, q_set, done}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of SUB
    dx = 4'd7; dy = 4'd2; go = 1'b1;
    for (int i = 0; i < 40 && cs != 3'd5; i++) @(negedge clk);
    check("reached_sub", int'(cs), 5);
    #1 rst = 1'b1; go = 1'b0;
    #1;
    check("rst_async_cs", int'(cs), 0);
    check("rst_async_err", int'(err), 0);
    check("rst_async_strobes", int'({cnt_ce, cnt_ld, ld_xy, shl, r_ld, q_set, done}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      int stray = 0;
      repeat (4) begin
        @(negedge clk);
        if (cs != 3'd0 || done) stray++;
      end
      check("idle_without_go", stray, 0);
    end

    // 7/2 with go held after DONE
    start_div(7, 2, 3, 1, 0, 16, 2);
    wait_done(1'b0);
    begin
      int held = 0;
      repeat (5) begin
        @(negedge clk);
        if (cs == 3'd7 && done) held++;
      end
      check("done_hold", held, 5);
    end
    drop_go();
    go = 1'b1;
    @(negedge clk);
    check("load_after_go", int'(cs), 1);
    go = 1'b0;
    sb.push_back('{q: 2, r: 0, e: 0, lat: 15, nq: 1});
    dx = 4'd6; dy = 4'd3;
    wait_done(1'b0);
    @(negedge clk);
    check("idle_after_done", int'(cs), 0);

    // 15/1 with go toggled during the iteration loop
    start_div(15, 1, 15, 0, 0, 18, 4);
    wait_done(1'b1);
    drop_go();

    start_div(3, 9, 0, 3, 0, 14, 0);
    wait_done(1'b0);
    drop_go();

    // Divide by zero, then a normal division clears err in LOAD
    start_div(5, 0, 5, 0, 1, 2, 0);
    wait_done(1'b0);
    check("div0_err", int'(err), 1);
    drop_go();
    start_div(6, 3, 2, 0, 0, 15, 1);
    @(negedge clk);
    check("check_state", int'(cs), 2);
    check("err_cleared", int'(err), 0);
    wait_done(1'b0);
    drop_go();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
